// File: rtl/regfile_fwd.sv
// regfile_fwd: RV32I architectural register file (x0..x31).
//   - One execute-stage write port, two combinational decode read ports.
//   - Same-cycle write-to-read bypass on both read ports.
//   - Retired-write counter (commits to x1..x31 only).
//   - Optional debug read/write port, enabled by defining REGFILE_DEBUG_EN.
module regfile_fwd #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       wr_addr_i,
    input  logic [XLEN-1:0]  wr_data_i,
    input  logic             wr_en_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
`ifdef REGFILE_DEBUG_EN
    input  logic [4:0]       dbg_addr_i,
    input  logic             dbg_wen_i,
    input  logic [XLEN-1:0]  dbg_wdata_i,
    output logic [XLEN-1:0]  dbg_rdata_o,
    output logic             dbg_collide_o,
`endif
    output logic [CNT_W-1:0] wr_cnt_o
);

    // Register bank; entry 0 is never written and is masked on read.
    logic [XLEN-1:0] regs [REG_NUM];

    logic exe_commit;

    // True when the address names a real, writable register (not x0).
    function automatic logic addr_writable(input logic [4:0] addr);
        return (addr != 5'd0) && (32'(addr) < REG_NUM);
    endfunction

    // Read mux shared by all read ports: x0 and out-of-range read 0,
    // a matching execute write is forwarded, otherwise the stored value.
    function automatic logic [XLEN-1:0] read_mux(
        input logic [4:0]      addr,
        input logic            fwd_valid,
        input logic [4:0]      fwd_addr,
        input logic [XLEN-1:0] fwd_data,
        input logic [XLEN-1:0] stored
    );
        if (!addr_writable(addr)) begin
            return '0;
        end else if (fwd_valid && (fwd_addr == addr)) begin
            return fwd_data;
        end else begin
            return stored;
        end
    endfunction

    // Execute-stage write qualifies only outside reset and away from x0.
    always_comb begin
        exe_commit = !rst && wr_en_i && addr_writable(wr_addr_i);
    end

`ifdef REGFILE_DEBUG_EN
    logic dbg_commit;
    logic dbg_hit_exe;

    // Debug write loses to an execute write aimed at the same register.
    always_comb begin
        dbg_hit_exe   = exe_commit && dbg_wen_i && (dbg_addr_i == wr_addr_i);
        dbg_commit    = !rst && dbg_wen_i && addr_writable(dbg_addr_i) && !dbg_hit_exe;
        dbg_collide_o = dbg_hit_exe;
    end

    // Debug read sees the execute-port bypass but never its own write data.
    always_comb begin
        if (rst) begin
            dbg_rdata_o = '0;
        end else begin
            dbg_rdata_o = read_mux(dbg_addr_i, exe_commit, wr_addr_i, wr_data_i,
                                   regs[dbg_addr_i]);
        end
    end
`endif

    // Register bank update: reset clears every entry and drops pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
`ifdef REGFILE_DEBUG_EN
            if (dbg_commit) begin
                regs[dbg_addr_i] <= dbg_wdata_i;
            end
`endif
            if (exe_commit) begin
                regs[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // Retired-write counter: execute commits only, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_o <= '0;
        end else if (exe_commit) begin
            wr_cnt_o <= wr_cnt_o + 1'b1;
        end
    end

    // Decode read ports with independent same-cycle bypass; held at 0 in reset.
    always_comb begin
        if (rst) begin
            rs1_data_o = '0;
            rs2_data_o = '0;
        end else begin
            rs1_data_o = read_mux(rs1_addr_i, exe_commit, wr_addr_i, wr_data_i,
                                  regs[rs1_addr_i]);
            rs2_data_o = read_mux(rs2_addr_i, exe_commit, wr_addr_i, wr_data_i,
                                  regs[rs2_addr_i]);
        end
    end

endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
- Architectural integer register file (x0..x31, 32-bit) for the RV32I core.
- Write port consumes the execute stage's rd_addr/rd_data/rd_wen outputs.
- Two read ports feed the decode stage's op1/op2 selection. Same-cycle write-to-read bypass, so decode sees a value being written back in the current cycle.
- Also keeps a retired-write counter and provides a compile-time optional debug access port.

Parameters:
- REG_NUM, 32, number of architectural registers (addresses 0..REG_NUM-1, 5-bit address).
- XLEN, 32, register width in bits.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_addr_i  input  5  destination register from execute stage.
- wr_data_i  input  XLEN  write data from execute stage.
- wr_en_i  input  1  write enable from execute stage.
- rs1_addr_i  input  5  decode read address, port 1.
- rs2_addr_i  input  5  decode read address, port 2.
- rs1_data_o  output  XLEN  read data, port 1 (combinational).
- rs2_data_o  output  XLEN  read data, port 2 (combinational).
- wr_cnt_o  output  CNT_W  count of committed writes to x1..x31.
- (REGFILE_DEBUG_EN only) dbg_addr_i  input  5; dbg_wen_i  input  1; dbg_wdata_i  input  XLEN; dbg_rdata_o  output  XLEN; dbg_collide_o  output  1.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - On a rising edge with rst=1, all registers clear to 0 and wr_cnt_o clears to 0.
  - Any write presented in that cycle is discarded.
  - While rst=1, rs1_data_o, rs2_data_o and dbg_rdata_o drive 0; dbg_collide_o drives 0.
- Write:
  - On a rising edge with rst=0, wr_en_i=1 and wr_addr_i!=0, the register at wr_addr_i takes wr_data_i.
  - The write is visible in the array from the next cycle.
- x0:
  - Writes to address 0 are ignored; x0 always reads 0.
  - Writes to x0 do not increment the counter.
- Read latency: 0 cycles (purely combinational from address and array state).
- Bypass:
  - If wr_en_i=1, wr_addr_i!=0 and wr_addr_i==rsN_addr_i, then rsN_data_o = wr_data_i in the same cycle.
  - Otherwise rsN_data_o = array[rsN_addr_i].
  - Both ports bypass independently; rs1_addr_i==rs2_addr_i==wr_addr_i returns wr_data_i on both.
- Counter:
  - wr_cnt_o increments by 1 on every committed write (wr_en_i=1, wr_addr_i!=0, rst=0).
  - Wraps from 2^CNT_W-1 to 0 with no flag.
- Unknown-free: every output is defined every cycle. No latches: the array is a clocked register bank; read muxes are fully specified.
- Reset mid-operation: rst asserted in the same cycle as a write drops the write and the count; after rst deasserts, all reads return 0 until new writes.

Optional Feature:
- Macro REGFILE_DEBUG_EN.
- Defined: adds the debug port.
  - dbg_rdata_o is a combinational read of dbg_addr_i, with the same bypass from the execute write port; x0 reads 0.
  - dbg_wen_i=1 writes dbg_wdata_i to dbg_addr_i on the next edge (ignored for address 0).
  - Debug writes do not increment wr_cnt_o.
  - If the execute write and the debug write target the same non-zero address in the same cycle, the execute write wins and dbg_collide_o=1 for that cycle (combinational).
  - Different addresses: both writes commit.
  - rs1/rs2 reads do not bypass debug write data.
- Undefined:
  - Debug ports are absent.
  - No debug logic is synthesized.
  - Remaining behaviour is identical.

Test Plan:
- Reset clears state: write x5=0x1234_5678, then assert rst 1 cycle; read rs1_addr=5 -> 0x0000_0000, wr_cnt_o=0.
- Basic write and count: write x3=0xDEAD_BEEF (wen=1), next cycle rs2_addr=3 -> 0xDEAD_BEEF, wr_cnt_o=1.
- Same-cycle bypass on both ports:
  - Stimulus: x7 holds 0x11; in the same cycle present write x7=0x22 with rs1_addr=rs2_addr=7.
  - Response: both outputs = 0x22 that cycle; next cycle with wen=0 both still read 0x22.
- x0 protection: write x0=0xFFFF_FFFF -> rs1_addr=0 reads 0 in that cycle and the next, wr_cnt_o unchanged.
- Reset overrides write: rst=1 with wen=1, x9=0xAA -> after reset x9 reads 0, wr_cnt_o=0.
- (REGFILE_DEBUG_EN) debug collision:
  - Stimulus: execute writes x4=0x1 and debug writes x4=0x2 in the same cycle.
  - Response: dbg_collide_o=1 that cycle; next cycle x4 reads 0x1 and wr_cnt_o has incremented by 1.
  - Follow-up: debug write x6=0x5 alone -> x6 reads 0x5, counter unchanged.
